// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type identifier codes and the responder state set.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SINGLE = 2'd2,
        ST_BURST  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_bram_resp_ram.sv
// 2^ADR_W x 32 block RAM: registered read port, byte-enable write port, one address each.
module wb_bram_resp_ram #(
    parameter int ADR_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADR_W-1:0] rd_adr,
    output logic [31:0]      rd_dat,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [3:0]       wr_sel,
    input  logic [31:0]      wr_dat
);

    logic [31:0] mem [2**ADR_W];
    logic [31:0] rd_dat_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_sel[i]) begin
                mem[wr_adr][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    // Only the output register is cleared; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= mem[rd_adr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/wb_bram_resp.sv
// Wishbone B4 block-RAM slave with optional wait states and incrementing-burst support.
module wb_bram_resp
    import wb_pkg::*;
#(
    parameter int ADR_W       = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [2:0]  wb_cti_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output wb_state_e   dbg_state_o
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    wb_state_e        state_q, state_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [ADR_W-1:0] beat_adr_q, beat_adr_d;
    logic [2:0]       cti_q, cti_d;

    logic [ADR_W-1:0] adr_idx;
    logic [ADR_W-1:0] rd_adr;
    logic             req;
    logic             ack;
    logic             last_beat;
    logic             unused_adr_bits;

    assign adr_idx         = wb_adr_i[ADR_W+1:2];
    assign unused_adr_bits = ^{wb_adr_i[31:ADR_W+2], wb_adr_i[1:0]};

    // Handshake: the master's request (cyc & stb) is the valid, wb_ack_o the ready; a beat
    // transfers in a cycle where both are high. Data states ack whenever the master strobes,
    // so stb low is a stall, and reset low suppresses ack so no write lands at the reset edge.
    always_comb begin
        req       = wb_cyc_i & wb_stb_i;
        ack       = sys_rst & req & ((state_q == ST_SINGLE) || (state_q == ST_BURST));
        last_beat = (wb_cti_i == CTI_EOB) || (wb_cti_i != CTI_INCR);

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_adr_d = beat_adr_q;
        cti_d      = cti_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    beat_adr_d = adr_idx;
                    cti_d      = wb_cti_i;
                    wait_cnt_d = '0;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = (cti_q == CTI_INCR) ? ST_BURST : ST_SINGLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_SINGLE: begin
                if (!wb_cyc_i || ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (ack) begin
                    beat_adr_d = beat_adr_q + ADR_W'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Look one word ahead on an acked beat so consecutive beats need no bubble.
        if (state_q == ST_IDLE) begin
            rd_adr = adr_idx;
        end else if (ack) begin
            rd_adr = beat_adr_q + ADR_W'(1);
        end else begin
            rd_adr = beat_adr_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            beat_adr_q <= '0;
            cti_q      <= CTI_CLASSIC;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_adr_q <= beat_adr_d;
            cti_q      <= cti_d;
        end
    end

    wb_bram_resp_ram #(
        .ADR_W(ADR_W)
    ) u_ram (
        .clk    (sys_clk),
        .rst_n  (sys_rst),
        .rd_adr (rd_adr),
        .rd_dat (wb_dat_o),
        .wr_en  (ack & wb_we_i),
        .wr_adr (beat_adr_q),
        .wr_sel (wb_sel_i),
        .wr_dat (wb_dat_i)
    );

    assign wb_ack_o    = ack;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_bram_resp.sv
// Bench for wb_bram_resp: three configurations driven by a scripted Wishbone master.
module tb_wb_bram_resp;
    import wb_pkg::*;

    typedef struct packed {
        logic        chk_ack;
        logic        ack;
        logic        chk_dat;
        logic        chk_idle;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] adr   [3];
    logic [31:0] dat_i [3];
    logic [31:0] dat_o [3];
    logic [2:0]  cti   [3];
    logic [3:0]  sel   [3];
    logic        ack_o [3];
    wb_state_e   st    [3];

    int ws  [3] = '{0, 0, 3};
    int dep [3] = '{1024, 16, 64};

    logic [31:0] mdl [3][1024];
    logic        vld [3][1024];
    exp_t        exp_q [3][$];
    exp_t        cmp_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    wb_bram_resp #(.ADR_W(10), .WAIT_STATES(0)) dut0 (
        .sys_clk(clk), .sys_rst(rst_n[0]), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]),
        .wb_dat_o(dat_o[0]), .wb_cti_i(cti[0]), .wb_sel_i(sel[0]), .wb_we_i(we[0]),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_ack_o(ack_o[0]), .dbg_state_o(st[0]));

    wb_bram_resp #(.ADR_W(4), .WAIT_STATES(0)) dut1 (
        .sys_clk(clk), .sys_rst(rst_n[1]), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]),
        .wb_dat_o(dat_o[1]), .wb_cti_i(cti[1]), .wb_sel_i(sel[1]), .wb_we_i(we[1]),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_ack_o(ack_o[1]), .dbg_state_o(st[1]));

    wb_bram_resp #(.ADR_W(6), .WAIT_STATES(3)) dut2 (
        .sys_clk(clk), .sys_rst(rst_n[2]), .wb_adr_i(adr[2]), .wb_dat_i(dat_i[2]),
        .wb_dat_o(dat_o[2]), .wb_cti_i(cti[2]), .wb_sel_i(sel[2]), .wb_we_i(we[2]),
        .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_ack_o(ack_o[2]), .dbg_state_o(st[2]));

    // Scoreboard: one expectation per instance per cycle; an empty queue means "no ack".
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() > 0) begin
                cmp_e = exp_q[d].pop_front();
            end else begin
                cmp_e = '0;
                cmp_e.chk_ack = 1'b1;
            end
            if (cmp_e.chk_ack) begin
                n_cmp++;
                if (ack_o[d] !== cmp_e.ack) begin
                    n_bad++;
                    $display("FAIL ack dut%0d t=%0t got %b want %b", d, $time, ack_o[d], cmp_e.ack);
                end
            end
            if (cmp_e.chk_dat) begin
                n_cmp++;
                if (dat_o[d] !== cmp_e.dat) begin
                    n_bad++;
                    $display("FAIL dat dut%0d t=%0t got %h want %h", d, $time, dat_o[d], cmp_e.dat);
                end
            end
            if (cmp_e.chk_idle) begin
                n_cmp++;
                if (st[d] !== ST_IDLE) begin
                    n_bad++;
                    $display("FAIL state dut%0d t=%0t got %0d want IDLE", d, $time, st[d]);
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [2:0] classic_cti();
        int r = $urandom_range(0, 6);
        return 3'(r < 2 ? r : r + 1);
    endfunction

    // Word index placed in the decoded field; byte-offset and high bits are random noise.
    function automatic logic [31:0] mk_adr(input int d, input int idx);
        logic [31:0] hi = $urandom;
        hi = hi & ~(32'(dep[d]) * 32'd4 - 32'd1);
        return hi | 32'(idx * 4) | 32'($urandom_range(0, 3));
    endfunction

    task automatic expect_cycle(input int d, input logic ca, input logic a, input logic cd,
                                input logic [31:0] dt, input logic ci);
        exp_t e;
        e.chk_ack  = ca;
        e.ack      = a;
        e.chk_dat  = cd;
        e.chk_idle = ci;
        e.dat      = dt;
        exp_q[d].push_back(e);
    endtask

    task automatic step(input int d, input logic ca, input logic a, input logic cd,
                        input logic [31:0] dt, input logic ci);
        expect_cycle(d, ca, a, cd, dt, ci);
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int d, input int idx, input logic [31:0] wd, input logic [3:0] s);
        mdl[d][idx] = merge(mdl[d][idx], wd, s);
        vld[d][idx] = vld[d][idx] | (s == 4'hF);
    endtask

    task automatic classic(input int d, input logic w, input int idx, input logic [31:0] wd,
                           input logic [3:0] s, input logic lit_en, input logic [31:0] lit);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        adr[d] = mk_adr(d, idx); dat_i[d] = wd; sel[d] = s; cti[d] = classic_cti();
        step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (ws[d]) step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        if (w) begin
            step(d, 1'b1, 1'b1, 1'b0, '0, 1'b0);
            model_write(d, idx, wd, s);
        end else begin
            step(d, 1'b1, 1'b1, lit_en | vld[d][idx], lit_en ? lit : mdl[d][idx], 1'b0);
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        step(d, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic burst(input int d, input logic w, input int start, input int n,
                         input int stall_beat, input int stall_len, input int abort_after,
                         input int rst_beat);
        int cur = start;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; cti[d] = CTI_INCR;
        adr[d] = mk_adr(d, cur); dat_i[d] = $urandom; sel[d] = 4'($urandom);
        step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (ws[d]) step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k == abort_after) begin
                cyc[d] = 1'b0; stb[d] = 1'b0;
                step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
                step(d, 1'b1, 1'b0, 1'b0, '0, 1'b1);
                return;
            end
            if (k == rst_beat) begin
                rst_n[d] = 1'b0; dat_i[d] = $urandom; sel[d] = 4'hF;
                step(d, 1'b0, 1'b0, 1'b0, '0, 1'b0);
                rst_n[d] = 1'b1; we[d] = 1'b0;
                step(d, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
                step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
                cyc[d] = 1'b0; stb[d] = 1'b0;
                step(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
                step(d, 1'b1, 1'b0, 1'b0, '0, 1'b1);
                return;
            end
            if (k == stall_beat) begin
                stb[d] = 1'b0; dat_i[d] = $urandom; sel[d] = 4'hF;
                repeat (stall_len) step(d, 1'b1, 1'b0, !w && vld[d][cur], mdl[d][cur], 1'b0);
            end
            if (k > 0) begin
                adr[d] = mk_adr(d, cur); dat_i[d] = $urandom; sel[d] = 4'($urandom);
            end
            stb[d] = 1'b1;
            cti[d] = (k == n - 1) ? classic_cti() : CTI_INCR;
            if (w) begin
                step(d, 1'b1, 1'b1, 1'b0, '0, 1'b0);
                model_write(d, cur, dat_i[d], sel[d]);
            end else begin
                step(d, 1'b1, 1'b1, vld[d][cur], mdl[d][cur], 1'b0);
            end
            cur = (cur + 1) % dep[d];
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        step(d, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = '0; dat_i[d] = '0; cti[d] = '0; sel[d] = '0;
            for (int i = 0; i < 1024; i++) vld[d][i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b1;
            expect_cycle(d, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
        end
        @(posedge clk);
        #1;

        // Classic write/read and byte lanes with literal results.
        classic(0, 1'b1, 4, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        classic(0, 1'b0, 4, '0, 4'hF, 1'b1, 32'hDEADBEEF);
        classic(0, 1'b1, 8, 32'h11223344, 4'hF, 1'b0, '0);
        classic(0, 1'b1, 8, 32'hAABBCCDD, 4'b0101, 1'b0, '0);
        classic(0, 1'b0, 8, '0, 4'hF, 1'b1, 32'h11BB33DD);

        // Burst of four from byte address 0x100 over words holding 0..3.
        for (int i = 0; i < 4; i++) classic(0, 1'b1, 64 + i, 32'(i), 4'hF, 1'b0, '0);
        classic(0, 1'b0, 66, '0, 4'hF, 1'b1, 32'h2);
        burst(0, 1'b0, 64, 4, -1, 0, 99, -1);

        // Stalled read and write bursts.
        for (int i = 0; i < 8; i++) classic(0, 1'b1, 128 + i, $urandom, 4'hF, 1'b0, '0);
        burst(0, 1'b0, 128, 4, 2, 2, 99, -1);
        burst(0, 1'b1, 128, 4, 2, 2, 99, -1);
        for (int i = 0; i < 4; i++) classic(0, 1'b0, 128 + i, '0, 4'hF, 1'b0, '0);

        // Randomized traffic over a preloaded window.
        for (int i = 0; i < 32; i++) classic(0, 1'b1, 768 + i, $urandom, 4'hF, 1'b0, '0);
        for (int it = 0; it < 24; it++) begin
            int op    = $urandom_range(0, 3);
            int base  = 768 + $urandom_range(0, 24);
            int n     = $urandom_range(2, 8);
            int sb    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
            case (op)
                0: classic(0, 1'b1, base, $urandom, 4'($urandom), 1'b0, '0);
                1: classic(0, 1'b0, base, '0, 4'hF, 1'b0, '0);
                2: burst(0, 1'b0, base, n, sb, $urandom_range(1, 3), 99, -1);
                default: burst(0, 1'b1, base, n, sb, $urandom_range(1, 3), 99, -1);
            endcase
        end

        // Small memory: wrap across the top and abort after two beats.
        for (int i = 0; i < 16; i++) classic(1, 1'b1, i, $urandom, 4'hF, 1'b0, '0);
        burst(1, 1'b0, 15, 3, -1, 0, 99, -1);
        burst(1, 1'b1, 14, 4, -1, 0, 2, -1);
        classic(1, 1'b0, 14, '0, 4'hF, 1'b0, '0);
        classic(1, 1'b0, 15, '0, 4'hF, 1'b0, '0);
        classic(1, 1'b0, 0, '0, 4'hF, 1'b0, '0);
        classic(1, 1'b0, 1, '0, 4'hF, 1'b0, '0);

        // Wait states, then reset in the middle of a write burst.
        classic(2, 1'b1, 5, 32'hCAFEF00D, 4'hF, 1'b0, '0);
        classic(2, 1'b0, 5, '0, 4'hF, 1'b1, 32'hCAFEF00D);
        for (int i = 0; i < 8; i++) classic(2, 1'b1, 8 + i, $urandom, 4'hF, 1'b0, '0);
        burst(2, 1'b0, 8, 3, -1, 0, 99, -1);
        burst(2, 1'b1, 8, 4, 1, 2, 99, 2);
        for (int i = 0; i < 4; i++) classic(2, 1'b0, 8 + i, '0, 4'hF, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_bram_resp.md
WB_BRAM_RESP -- requirements
Module: wb_bram_resp

Interface
REQ-001 The block SHALL have parameter ADR_W, default 10, giving memory depth as 2^ADR_W 32-bit words.
REQ-002 The block SHALL have parameter WAIT_STATES, default 0 (range 0-7), giving extra cycles before the first ack of each cycle.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port wb_adr_i, input, 32 bits: byte address; word index = wb_adr_i[ADR_W+1:2], other bits ignored.
REQ-006 The block SHALL have port wb_dat_i, input, 32 bits: write data.
REQ-007 The block SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-008 The block SHALL have port wb_cti_i, input, 3 bits: cycle type identifier.
REQ-009 The block SHALL have port wb_sel_i, input, 4 bits: byte lane enables, bit n = bits 8n+7:8n.
REQ-010 The block SHALL have ports wb_we_i, wb_cyc_i and wb_stb_i, each input, 1 bit: write enable, cycle valid and strobe.
REQ-011 The block SHALL have port wb_ack_o, output, 1 bit: cycle termination.

Function
REQ-012 States SHALL be IDLE, WAIT, SINGLE and BURST.
REQ-013 A request SHALL be wb_cyc_i & wb_stb_i sampled in IDLE; the word index and wb_cti_i SHALL be captured into beat_adr and cti_q.
- Next state: WAIT if WAIT_STATES>0.
- Otherwise SINGLE if cti_q != 3'b010, BURST if cti_q == 3'b010.
REQ-014 WAIT SHALL count WAIT_STATES cycles, then go to SINGLE or BURST by cti_q; if wb_cyc_i drops, it SHALL return to IDLE.
REQ-015 Classic read latency SHALL be exactly 1+WAIT_STATES cycles from the request edge to wb_ack_o high.
REQ-016 SINGLE SHALL assert wb_ack_o for exactly one cycle, then return to IDLE.
REQ-017 wb_cti_i values 001, 011-110 and 111 at request time SHALL be treated as classic cycles.
REQ-018 In BURST, wb_ack_o SHALL equal wb_cyc_i & wb_stb_i combinationally.
- A cycle with stb low SHALL be a stall: no ack, beat_adr held, wb_dat_o held.
REQ-019 On each acked BURST beat, beat_adr SHALL increment by 1 modulo 2^ADR_W (wrap from 2^ADR_W-1 to 0).
REQ-020 The RAM read address SHALL be beat_adr+1 when the current cycle is acked, else beat_adr, so that back-to-back beats return consecutive words with no bubble.
REQ-021 An acked BURST beat sampled with wb_cti_i=111, or with wb_cti_i other than 010, SHALL be the last beat; the next state SHALL be IDLE.
REQ-022 The memory SHALL be written only on the clock edge ending a cycle with wb_ack_o=1 and wb_we_i=1.
- Write address: beat_adr.
- Only lanes with wb_sel_i set SHALL be written.
- Each beat SHALL be written exactly once.
REQ-023 wb_dat_o SHALL be valid whenever wb_ack_o=1 and wb_we_i=0, and SHALL be don't-care otherwise.
REQ-024 wb_cyc_i low in any state SHALL force IDLE on the next edge, with wb_ack_o low in that cycle; memory content SHALL be unaffected except beats already acked.
REQ-025 IDLE SHALL never assert wb_ack_o, so a classic master holding stb one cycle after ack never gets a duplicate ack or write.

Reset
REQ-026 While sys_rst=0 at a clock edge, the block SHALL set state to IDLE, the wait counter to 0, beat_adr to 0, cti_q to 000 and wb_ack_o to 0.
REQ-027 wb_dat_o SHALL reset to 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-burst SHALL abort the burst with no further write.

Structure
REQ-030 The shared package wb_pkg SHALL hold the CTI constants (CLASSIC=000, CONST=001, INCR=010, EOB=111) and the state enumeration.
REQ-031 One sub-module, wb_bram_resp_ram, SHALL implement a 2^ADR_W x 32 synchronous-read, byte-enable-write RAM with a single read/write address pair; all control SHALL stay in wb_bram_resp.

Verification
REQ-032 Classic write then read (W=0): write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 -> ack exactly 1 cycle after each request, read returns 0xDEADBEEF.
REQ-033 Byte lanes: preload 0x11223344 at 0x20, write 0xAABBCCDD with sel=0101, read back -> 0x11BB33DD.
REQ-034 Read burst of 4 from 0x100 (cti 010,010,010,111) on preloaded words 0..3 -> acks on 4 consecutive cycles, data 0,1,2,3, then state IDLE.
REQ-035 Burst with a stall (stb low on beat 2 for 2 cycles) -> no ack during the stall, data word 2 held, beat 3 correct; no write during a stall in write bursts.
REQ-036 Wrap and abort (ADR_W=4): burst from word 15 -> second beat reads word 0; drop cyc after 2 beats -> IDLE next cycle, only 2 words written.
REQ-037 WAIT_STATES=3 and reset: classic read -> ack 4 cycles after the request; sys_rst=0 asserted mid-burst -> ack low the next cycle and all outputs at reset values.
